// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: one-character sequencer in front of the SPI shift register.
// Optional transfer watchdog enabled by defining SPI_XFER_TIMEOUT_EN.
module spi_xfer_seq #(
  parameter int SS_W = 8,
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_data,
  input  logic [4:0]      cmd_len,
  input  logic [SS_W-1:0] cmd_ss,
  input  logic            cmd_last,
  input  logic [7:0]      cfg_setup,
  input  logic [7:0]      cfg_hold,
  output logic [3:0]      sh_latch,
  output logic [3:0]      sh_byte_sel,
  output logic [31:0]     sh_p_in,
  output logic [4:0]      sh_len,
  output logic            sh_go,
  input  logic            sh_tip,
  input  logic [31:0]     sh_p_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic [SS_W-1:0] ss_pad_o,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETUP, GO, WAIT, RSP, HOLD
  } state_t;

  state_t state_q, state_d;

  logic            alive_q;
  logic            first_q;
  logic            last_q;
  logic            err_q;
  logic [31:0]     data_q;
  logic [31:0]     rdata_q;
  logic [4:0]      len_q;
  logic [SS_W-1:0] ss_q;
  logic [SS_W-1:0] ss_pad_q;
  logic [7:0]      cnt_q;

  logic        accept;
  logic        set_ss;
  logic        rel_ss;
  logic        cnt_inc;
  logic        capture;
  logic        timeout;
  logic        to_expire;
  logic        ss_idle;
  logic        hold_done;
  logic [31:0] mask;

  assign ss_idle = &ss_pad_q;

  // SS stays low for cfg_hold cycles counted from the handshake cycle
  assign hold_done = ({1'b0, cnt_q} + 9'd2) >= {1'b0, cfg_hold};

  assign mask = (len_q == 5'd0) ? 32'hFFFF_FFFF
              : (32'hFFFF_FFFF >> (5'd31 - len_q));

`ifdef SPI_XFER_TIMEOUT_EN
  logic [TO_W-1:0] to_q;

  // watchdog runs only while waiting for the shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else if (state_q == WAIT) begin
      to_q <= to_q + 1'b1;
    end else begin
      to_q <= '0;
    end
  end

  assign to_expire = &to_q;
`else
  assign to_expire = 1'b0 & (TO_W > 0);
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and control strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    set_ss  = 1'b0;
    rel_ss  = 1'b0;
    cnt_inc = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && alive_q) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (ss_idle) begin
          set_ss  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = GO;
        end
      end
      SETUP: begin
        if (cnt_q == cfg_setup) begin
          state_d = GO;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      GO: state_d = WAIT;
      WAIT: begin
        if (!first_q && !sh_tip) begin
          capture = 1'b1;
          state_d = RSP;
        end else if (to_expire) begin
          capture = 1'b1;
          timeout = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d = (last_q || err_q) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (hold_done) begin
          rel_ss  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // command capture, SS pad, delay counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
      len_q    <= '0;
      ss_q     <= '0;
      ss_pad_q <= '1;
      cnt_q    <= '0;
    end else begin
      alive_q <= 1'b1;
      first_q <= (state_q == GO);
      cnt_q   <= cnt_inc ? cnt_q + 8'd1 : 8'd0;
      if (accept) begin
        data_q <= cmd_data;
        len_q  <= cmd_len;
        ss_q   <= cmd_ss;
        last_q <= cmd_last;
      end
      if (set_ss) begin
        ss_pad_q <= ~ss_q;
      end else if (rel_ss) begin
        ss_pad_q <= '1;
      end
      if (capture) begin
        rdata_q <= sh_p_out & mask;
        err_q   <= timeout;
      end
    end
  end

  assign cmd_ready   = alive_q && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign sh_latch    = (state_q == LOAD) ? 4'b0001 : 4'b0000;
  assign sh_byte_sel = (state_q == LOAD) ? 4'b1111 : 4'b0000;
  assign sh_p_in     = data_q;
  assign sh_len      = len_q;
  assign sh_go       = (state_q == GO);
  assign rsp_valid   = (state_q == RSP);
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q & rsp_valid;
  assign ss_pad_o    = ss_pad_q;

endmodule

// File: tb/tb_spi_xfer_seq.sv
// tb_spi_xfer_seq: scoreboard bench for spi_xfer_seq.
// Loopback shift-register model; watchdog case built with SPI_XFER_TIMEOUT_EN.
module tb_spi_xfer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic [4:0]  cmd_len;
  logic [7:0]  cmd_ss;
  logic        cmd_last;
  logic [7:0]  cfg_setup;
  logic [7:0]  cfg_hold;
  logic [3:0]  sh_latch;
  logic [3:0]  sh_byte_sel;
  logic [31:0] sh_p_in;
  logic [4:0]  sh_len;
  logic        sh_go;
  logic        sh_tip;
  logic [31:0] sh_p_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  ss_pad_o;
  logic        busy;

  spi_xfer_seq #(.SS_W(8), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_len(cmd_len),
    .cmd_ss(cmd_ss), .cmd_last(cmd_last),
    .cfg_setup(cfg_setup), .cfg_hold(cfg_hold),
    .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel),
    .sh_p_in(sh_p_in), .sh_len(sh_len), .sh_go(sh_go),
    .sh_tip(sh_tip), .sh_p_out(sh_p_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ss_pad_o(ss_pad_o), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        err;
    logic        hold;
  } exp_t;

  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // shift register model: loads on latch, busy 5 cycles after go
  logic [31:0] sh_reg = '0;
  int          tip_cnt = 0;
  logic        stuck = 1'b0;

  always @(posedge clk) begin
    if (sh_latch[0]) sh_reg <= sh_p_in;
    if (sh_go) tip_cnt <= 5;
    else if (tip_cnt > 0) tip_cnt <= tip_cnt - 1;
  end

  assign sh_tip   = stuck | (tip_cnt != 0);
  assign sh_p_out = sh_reg;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_mask(input logic [4:0] l);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (l == 5'd0 || i <= int'(l)) m[i] = 1'b1;
    return m;
  endfunction

  // monitor state
  int         acc_cyc = 0;
  int         go_cyc  = 0;
  int         hs_cyc  = 0;
  int         exp_lat = 0;
  int         rise_cnt = 0;
  bit         hs_pend = 1'b0;
  logic [7:0] exp_ss_n = 8'hFF;
  logic [7:0] ss_d1 = 8'hFF;
  logic [7:0] ss_d2 = 8'hFF;

  // monitor: timing checks and scoreboard pops on response handshakes
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (sh_go) begin
        go_cyc = cyc;
        chk("go_latency", cyc - acc_cyc, exp_lat);
        chk("ss_at_go", {24'b0, ss_pad_o}, {24'b0, exp_ss_n});
        if (exp_lat > 2)
          chk("ss_2_before_go", {24'b0, ss_d2}, {24'b0, exp_ss_n});
      end
      if (ss_pad_o == 8'hFF && ss_d1 != 8'hFF) begin
        rise_cnt++;
        if (hs_pend) begin
          chk("ss_hold_cycles", cyc - hs_cyc, {24'b0, cfg_hold});
          hs_pend = 1'b0;
        end
      end
      if (rsp_valid && rsp_ready) begin
        hs_cyc = cyc;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %h expected none", rsp_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
          if (e.err) chk("timeout_cycles", cyc - go_cyc, 17);
          hs_pend = e.hold;
        end
      end
    end
    ss_d2 = ss_d1;
    ss_d1 = ss_pad_o;
  end

  task automatic send(input logic [31:0] d, input logic [4:0] l,
                      input logic [7:0] s, input logic last,
                      input int lat, input logic [7:0] ss_n,
                      input bit keep, input logic err);
    int t;
    exp_t e;
    t = 0;
    while (!cmd_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_ready_wait: got 0 expected 1");
    end
    exp_lat  = lat;
    exp_ss_n = ss_n;
    if (keep) begin
      e.d    = d & mk_mask(l);
      e.err  = err;
      e.hold = last | err;
      q.push_back(e);
    end
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_len   = l;
    cmd_ss    = s;
    cmd_last  = last;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while ((q.size() != 0 || busy) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0 || busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    int t;
    int r0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_len   = '0;
    cmd_ss    = '0;
    cmd_last  = 1'b0;
    cfg_setup = 8'd2;
    cfg_hold  = 8'd3;
    rsp_ready = 1'b1;

    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst_ss", {24'b0, ss_pad_o}, 32'hFF);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_go", {31'b0, sh_go}, 0);
    chk("rst_latch", {28'b0, sh_latch}, 0);
    chk("rst_bsel", {28'b0, sh_byte_sel}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {31'b0, cmd_ready}, 1);

    // single character with setup and hold
    send(32'hA5, 5'd7, 8'h01, 1'b1, 5, 8'hFE, 1, 0);
    drain();
    chk("ss_idle_after_1", {24'b0, ss_pad_o}, 32'hFF);

    // masking of upper bits
    send(32'h1234_5678, 5'd15, 8'h02, 1'b1, 5, 8'hFD, 1, 0);
    drain();

    // back-to-back: SS held, second skips setup, ss change ignored
    r0 = rise_cnt;
    send(32'h3C, 5'd7, 8'h01, 1'b0, 5, 8'hFE, 1, 0);
    send(32'hC3, 5'd7, 8'h02, 1'b1, 2, 8'hFE, 1, 0);
    drain();
    chk("b2b_one_release", rise_cnt - r0, 1);

    // full 32-bit word
    send(32'hDEAD_BEEF, 5'd0, 8'h01, 1'b1, 5, 8'hFE, 1, 0);
    drain();

    // response back-pressure for 10 cycles
    rsp_ready = 1'b0;
    send(32'h5A, 5'd7, 8'h01, 1'b1, 5, 8'hFE, 1, 0);
    t = 0;
    while (!rsp_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid_seen", {31'b0, rsp_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 1);
      chk("stall_data", rsp_data, 32'h5A);
      chk("stall_ready", {31'b0, cmd_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_left_rsp", {31'b0, rsp_valid}, 0);
    drain();

    // reset during WAIT
    send(32'h77, 5'd7, 8'h01, 1'b1, 5, 8'hFE, 0, 0);
    t = 0;
    while (!sh_tip && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_busy", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ss", {24'b0, ss_pad_o}, 32'hFF);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h99, 5'd7, 8'h04, 1'b1, 5, 8'hFB, 1, 0);
    drain();

`ifdef SPI_XFER_TIMEOUT_EN
    // watchdog: shifter never finishes, SS forced released
    stuck = 1'b1;
    send(32'h0000_1234, 5'd15, 8'h01, 1'b0, 5, 8'hFE, 1, 1);
    drain();
    stuck = 1'b0;
    chk("to_ss_released", {24'b0, ss_pad_o}, 32'hFF);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
